hyperbus_mem_resp: RTL

- Device-side HyperBus responder at word level; the counterpart to the controller PHY.
- One `clk_i` cycle carries one 16-bit DDR word pair.
- Decodes the 48-bit CA phase, applies initial latency, then serves read bursts from an internal memory or absorbs masked write bursts.
- Used as a synthesizable memory stand-in in the hyperbus testbench and in FPGA loopback builds.

---
 rtl/hyperbus_pkg.sv | 25 ++
 rtl/hyperbus_resp_mem.sv | 32 +++
 rtl/hyperbus_mem_resp.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared HyperBus types: CA word layout and responder states
package hyperbus_pkg;

  localparam int HyperWordW   = 16;
  localparam int HyperCaWords = 3;

  // 48-bit command/address phase, MSB first on the bus
  typedef struct packed {
    logic        read;          // 1 = read, 0 = write
    logic        reg_space;     // 1 = register space
    logic        burst_linear;  // 1 = linear, 0 = wrapped
    logic [28:0] addr_upper;
    logic [12:0] reserved;
    logic [2:0]  addr_lower;
  } hyper_phy_ca_t;

  typedef enum logic [2:0] {
    RESP_IDLE,
    RESP_CA,
    RESP_LATENCY,
    RESP_READ,
    RESP_WRITE
  } hyper_resp_state_t;

endpackage

// File: rtl/hyperbus_resp_mem.sv
// rtl/hyperbus_resp_mem.sv - single-port word array with byte write mask and registered read
module hyperbus_resp_mem
  import hyperbus_pkg::*;
#(
  parameter int MemWords = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [1:0]                  be_i,
  input  logic [$clog2(MemWords)-1:0] addr_i,
  input  logic [HyperWordW-1:0]       wdata_i,
  output logic [HyperWordW-1:0]       rdata_o
);

  logic [HyperWordW-1:0] mem_q [MemWords];

  // byte-masked write; the array itself is never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end
  end

  // registered read, addressed every cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else         rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/hyperbus_mem_resp.sv
// rtl/hyperbus_mem_resp.sv - word-level HyperBus device responder (wrapped bursts under HYPERBUS_RESP_WRAP_EN)
module hyperbus_mem_resp
  import hyperbus_pkg::*;
#(
  parameter int MemWords  = 1024,
  parameter int RegWords  = 4,
  parameter int WrapWords = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic        rwds_o,
  output logic        rwds_oe_o,
  input  logic [3:0]  t_latency_access_i,
  input  logic        en_latency_additional_i,
  output logic        busy_o
);

  localparam int MemAw = $clog2(MemWords);
  localparam int RegAw = $clog2(RegWords);

  hyper_resp_state_t state_q;
  logic [31:0]       ca_hi_q;
  logic [1:0]        ca_cnt_q;
  logic [4:0]        lat_cnt_q;
  logic              read_q, reg_space_q, linear_q;
  logic [MemAw-1:0]  addr_q, addr_next;
  logic              dq_oe_q, rwds_q, rwds_oe_q, busy_q;
  logic [15:0]       regs_q [RegWords];
  logic [15:0]       reg_rdata_q, mem_rdata;
  hyper_phy_ca_t     ca;
  logic [31:0]       ca_addr;
  logic [3:0]        lat_base;
  logic [4:0]        lat_load;
  logic              ca_last, lat_last, wr_active, addr_adv;

  // w0/w1 are held, w2 is taken live so decode happens on the w2 cycle
  assign ca       = {ca_hi_q, dq_i};
  assign ca_addr  = {ca.addr_upper, ca.addr_lower};
  assign ca_last  = (state_q == RESP_CA) && (ca_cnt_q == 2'(HyperCaWords - 1));
  assign lat_last = (state_q == RESP_LATENCY) && (lat_cnt_q == 5'd1);
  assign lat_base = (t_latency_access_i == 4'd0) ? 4'd1 : t_latency_access_i;
  assign lat_load = en_latency_additional_i ? {lat_base, 1'b0} : {1'b0, lat_base};

  assign wr_active = (state_q == RESP_WRITE) && !cs_ni;
  // reads pre-fetch: the address advances on the last latency cycle and every read cycle
  assign addr_adv  = !cs_ni && ((lat_last && read_q) || (state_q == RESP_READ) ||
                                (state_q == RESP_WRITE));

  // next burst address, optionally wrapping inside the aligned group
  always_comb begin
    addr_next = addr_q + 1'b1;
`ifdef HYPERBUS_RESP_WRAP_EN
    if (!linear_q) begin
      addr_next = {addr_q[MemAw-1:$clog2(WrapWords)], addr_q[$clog2(WrapWords)-1:0] + 1'b1};
    end
`endif
  end

`ifndef HYPERBUS_RESP_WRAP_EN
  logic unused_wrap;
  assign unused_wrap = linear_q ^ (WrapWords > 0);
`endif

  logic unused_ca;
  assign unused_ca = ^{ca_addr[31:MemAw], ca.reserved};

  // transaction state machine with registered pad controls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RESP_IDLE;
      ca_hi_q     <= '0;
      ca_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      read_q      <= 1'b0;
      reg_space_q <= 1'b0;
      linear_q    <= 1'b0;
      dq_oe_q     <= 1'b0;
      rwds_q      <= 1'b0;
      rwds_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (cs_ni) begin
      state_q   <= RESP_IDLE;
      ca_cnt_q  <= '0;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        RESP_IDLE: begin
          ca_hi_q[31:16] <= dq_i;
          ca_cnt_q       <= 2'd1;
          state_q        <= RESP_CA;
          busy_q         <= 1'b1;
          rwds_oe_q      <= 1'b1;
          rwds_q         <= en_latency_additional_i;
        end
        RESP_CA: begin
          rwds_q <= en_latency_additional_i;
          if (ca_last) begin
            read_q      <= ca.read;
            reg_space_q <= ca.reg_space;
            linear_q    <= ca.burst_linear;
            lat_cnt_q   <= lat_load;
            rwds_oe_q   <= 1'b0;
            rwds_q      <= 1'b0;
            state_q     <= (ca.reg_space && !ca.read) ? RESP_WRITE : RESP_LATENCY;
          end else begin
            ca_hi_q[15:0] <= dq_i;
            ca_cnt_q      <= ca_cnt_q + 2'd1;
          end
        end
        RESP_LATENCY: begin
          if (lat_last) begin
            state_q   <= read_q ? RESP_READ : RESP_WRITE;
            dq_oe_q   <= read_q;
            rwds_oe_q <= read_q;
            rwds_q    <= read_q;
          end else begin
            lat_cnt_q <= lat_cnt_q - 5'd1;
          end
        end
        RESP_READ, RESP_WRITE: begin
          state_q <= state_q;
        end
        default: state_q <= RESP_IDLE;
      endcase
    end
  end

  // burst address: loaded from the CA on w2, then advanced per word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      addr_q <= '0;
    else if (!cs_ni && ca_last) addr_q <= ca_addr[MemAw-1:0];
    else if (addr_adv) addr_q <= addr_next;
  end

  // register space: masked writes and a registered read matching the array timing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RegWords; i++) regs_q[i] <= '0;
      reg_rdata_q <= '0;
    end else begin
      reg_rdata_q <= regs_q[addr_q[RegAw-1:0]];
      if (wr_active && reg_space_q) begin
        if (!rwds_i[0]) regs_q[addr_q[RegAw-1:0]][7:0]  <= dq_i[7:0];
        if (!rwds_i[1]) regs_q[addr_q[RegAw-1:0]][15:8] <= dq_i[15:8];
      end
    end
  end

  hyperbus_resp_mem #(
    .MemWords (MemWords)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_active && !reg_space_q),
    .be_i    (~rwds_i),
    .addr_i  (addr_q),
    .wdata_i (dq_i),
    .rdata_o (mem_rdata)
  );

  // enables fall the same cycle chip select rises
  assign dq_oe_o   = dq_oe_q && !cs_ni;
  assign rwds_oe_o = rwds_oe_q && !cs_ni;
  assign rwds_o    = rwds_q && !cs_ni;
  assign dq_o      = dq_oe_o ? (reg_space_q ? reg_rdata_q : mem_rdata) : 16'h0000;
  assign busy_o    = busy_q;

endmodule
